// File: rtl/core_inst_pkg.sv
// Instruction-word layout shared by the corelet and its sequencer: field bit
// positions, the idle word and the sequencer state encoding.
package core_inst_pkg;

    localparam int INST_W     = 35;
    localparam int RELU_B     = 34;
    localparam int ACC_B      = 33;
    localparam int CEN_P_B    = 32;
    localparam int WEN_P_B    = 31;
    localparam int A_P_LSB    = 20;
    localparam int CEN_X_B    = 19;
    localparam int WEN_X_B    = 18;
    localparam int A_X_LSB    = 7;
    localparam int OFIFO_RD_B = 6;
    localparam int L0_RD_B    = 3;
    localparam int L0_WR_B    = 2;
    localparam int EXEC_B     = 1;
    localparam int LOAD_B     = 0;

    // Both SRAMs deselected with write-enable high; every other field zero.
    localparam logic [INST_W-1:0] IDLE_INST = 35'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_FILL = 3'd1,
        S_W_LOAD = 3'd2,
        S_X_FILL = 3'd3,
        S_EXEC   = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } seq_state_e;

endpackage

// File: rtl/corelet_seq.sv
// Tile instruction sequencer: for each kernel position fills L0 with weights,
// loads the MAC array, streams activations, executes and drains psums to PMEM.
module corelet_seq
    import core_inst_pkg::*;
#(
    parameter int row        = 8,
    parameter int col        = 8,
    parameter int inst_width = 35,
    parameter int addr_w     = 11,
    parameter int n_act      = 36,
    parameter int n_kij      = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_w-1:0]     w_base,
    input  logic [addr_w-1:0]     x_base,
    input  logic [addr_w-1:0]     p_base,
    input  logic                  l0_full,
    input  logic                  l0_ready,
    input  logic                  ofifo_valid,
    output logic [inst_width-1:0] inst,
    output logic                  busy,
    output logic                  done
);

    localparam int LOAD_CYC = 2 * col;
    localparam int CNT_M1   = (row > LOAD_CYC) ? row : LOAD_CYC;
    localparam int CNT_MAX  = (CNT_M1 > n_act) ? CNT_M1 : n_act;
    localparam int IDX_W    = $clog2(CNT_MAX + 2);
    localparam int KIJ_W    = (n_kij > 1) ? $clog2(n_kij) : 1;

    localparam logic [IDX_W-1:0]      ROW_I       = IDX_W'(row);
    localparam logic [IDX_W-1:0]      COL_I       = IDX_W'(col);
    localparam logic [IDX_W-1:0]      LOAD_LAST_I = IDX_W'(LOAD_CYC - 1);
    localparam logic [IDX_W-1:0]      ACT_I       = IDX_W'(n_act);
    localparam logic [IDX_W-1:0]      ACT_LAST_I  = IDX_W'(n_act - 1);
    localparam logic [KIJ_W-1:0]      KIJ_LAST    = KIJ_W'(n_kij - 1);
    localparam logic [inst_width-1:0] IDLE_W      = inst_width'(IDLE_INST);

    seq_state_e              state_q, state_d;
    logic [KIJ_W-1:0]        kij_q, kij_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    rd_pend_q, rd_pend_d;
    logic                    wr_pend_q, wr_pend_d;
    logic [addr_w-1:0]       w_base_q, w_base_d;
    logic [addr_w-1:0]       x_base_q, x_base_d;
    logic [addr_w-1:0]       p_base_q, p_base_d;
    logic [inst_width-1:0]   inst_q, inst_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    wfill_rd;
    logic                    xfill_rd;
    logic                    load_rd;
    logic                    drain_rd;
    logic [addr_w-1:0]       w_addr;
    logic [addr_w-1:0]       x_addr;
    logic [addr_w-1:0]       p_addr;

    // Reads issued so far in DRAIN are the completed writes plus the one pending.
    assign wfill_rd = (idx_q < ROW_I) && !l0_full;
    assign xfill_rd = (idx_q < ACT_I) && !l0_full;
    assign load_rd  = (idx_q < COL_I) && l0_ready;
    assign drain_rd = ofifo_valid && ((idx_q + IDX_W'(wr_pend_q)) < ACT_I);

    assign w_addr = w_base_q + addr_w'(kij_q) * addr_w'(row) + addr_w'(idx_q);
    assign x_addr = x_base_q + addr_w'(idx_q);
    assign p_addr = p_base_q + addr_w'(kij_q) * addr_w'(n_act) + addr_w'(idx_q);

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

    // State, counters, captured bases and the registered output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            kij_q     <= '0;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            w_base_q  <= '0;
            x_base_q  <= '0;
            p_base_q  <= '0;
            inst_q    <= IDLE_W;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kij_q     <= kij_d;
            idx_q     <= idx_d;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            w_base_q  <= w_base_d;
            x_base_q  <= x_base_d;
            p_base_q  <= p_base_d;
            inst_q    <= inst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state and counter updates.
    always_comb begin
        state_d   = state_q;
        kij_d     = kij_q;
        idx_d     = idx_q;
        rd_pend_d = 1'b0;
        wr_pend_d = 1'b0;
        w_base_d  = w_base_q;
        x_base_d  = x_base_q;
        p_base_d  = p_base_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // The first weight read is issued straight from the start cycle.
                    state_d   = S_W_FILL;
                    kij_d     = '0;
                    w_base_d  = w_base;
                    x_base_d  = x_base;
                    p_base_d  = p_base;
                    rd_pend_d = !l0_full;
                    idx_d     = l0_full ? IDX_W'(1'b0) : IDX_W'(1'b1);
                end else begin
                    idx_d = '0;
                end
            end
            S_W_FILL: begin
                rd_pend_d = wfill_rd;
                if (wfill_rd) begin
                    idx_d = idx_q + IDX_W'(1'b1);
                end else if (idx_q == ROW_I) begin
                    state_d = S_W_LOAD;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q;
                end
            end
            S_W_LOAD: begin
                if (idx_q < COL_I) begin
                    idx_d = load_rd ? idx_q + IDX_W'(1'b1) : idx_q;
                end else if (idx_q == LOAD_LAST_I) begin
                    state_d = S_X_FILL;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1'b1);
                end
            end
            S_X_FILL: begin
                rd_pend_d = xfill_rd;
                if (xfill_rd) begin
                    idx_d = idx_q + IDX_W'(1'b1);
                end else if (idx_q == ACT_I) begin
                    state_d = S_EXEC;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q;
                end
            end
            S_EXEC: begin
                if (!l0_ready) begin
                    idx_d = idx_q;
                end else if (idx_q == ACT_LAST_I) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1'b1);
                end
            end
            S_DRAIN: begin
                wr_pend_d = drain_rd;
                if (!wr_pend_q) begin
                    idx_d = idx_q;
                end else if (idx_q != ACT_LAST_I) begin
                    idx_d = idx_q + IDX_W'(1'b1);
                end else if (kij_q == KIJ_LAST) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    state_d = S_W_FILL;
                    kij_d   = kij_q + KIJ_W'(1'b1);
                    idx_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                kij_d   = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                kij_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Per-state instruction fields for the next cycle, plus busy/done.
    always_comb begin
        inst_d = IDLE_W;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start && !l0_full) begin
                    inst_d[CEN_X_B]             = 1'b0;
                    inst_d[A_X_LSB +: addr_w]   = w_base;
                end else begin
                    inst_d = IDLE_W;
                end
            end
            S_W_FILL, S_X_FILL: begin
                inst_d[L0_WR_B] = rd_pend_q;
                if ((state_q == S_W_FILL) ? wfill_rd : xfill_rd) begin
                    inst_d[CEN_X_B]           = 1'b0;
                    inst_d[A_X_LSB +: addr_w] = (state_q == S_W_FILL) ? w_addr : x_addr;
                end else begin
                    inst_d[CEN_X_B] = 1'b1;
                end
            end
            S_W_LOAD: begin
                inst_d[L0_RD_B] = load_rd;
                inst_d[LOAD_B]  = load_rd;
            end
            S_EXEC: begin
                inst_d[L0_RD_B] = l0_ready;
                inst_d[EXEC_B]  = l0_ready;
            end
            S_DRAIN: begin
                inst_d[OFIFO_RD_B] = drain_rd;
                if (wr_pend_q) begin
                    inst_d[CEN_P_B]           = 1'b0;
                    inst_d[WEN_P_B]           = 1'b0;
                    inst_d[A_P_LSB +: addr_w] = p_addr;
                end else begin
                    inst_d[CEN_P_B] = 1'b1;
                end
            end
            S_DONE: begin
                inst_d = IDLE_W;
            end
            default: begin
                inst_d = IDLE_W;
            end
        endcase
    end

endmodule

// File: tb/tb_corelet_seq.sv
// Self-checking bench for corelet_seq: a table of tile configurations plus
// hand-written sequences for first-cycle timing and reset during EXEC.
module tb_corelet_seq;

    localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] w_base = 11'd0, x_base = 11'd0, p_base = 11'd0;
    logic        l0_full = 1'b0, l0_ready = 1'b1, ofifo_valid = 1'b1;
    logic [34:0] inst;
    logic        busy, done;

    corelet_seq #(
        .row(8), .col(8), .inst_width(35), .addr_w(11), .n_act(4), .n_kij(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .p_base(p_base),
        .l0_full(l0_full), .l0_ready(l0_ready), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Event monitor, sampled on the falling edge.
    logic [10:0] xq[$];
    logic [10:0] pq[$];
    int n_l0wr = 0, n_load = 0, n_exec = 0, n_ofrd = 0, n_done = 0;
    int n_lag = 0, n_bad = 0, cyc = 0, last_pw_cyc = 0, done_cyc = 0;
    logic prev_xrd = 1'b0, prev_ofrd = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (inst[19] === 1'b0) xq.push_back(inst[17:7]);
        if (inst[2] === 1'b1) n_l0wr <= n_l0wr + 1;
        if (inst[3] === 1'b1 && inst[0] === 1'b1) n_load <= n_load + 1;
        if (inst[3] === 1'b1 && inst[1] === 1'b1) n_exec <= n_exec + 1;
        if (inst[6] === 1'b1) n_ofrd <= n_ofrd + 1;
        if (inst[32] === 1'b0) begin
            pq.push_back(inst[30:20]);
            last_pw_cyc <= cyc;
        end
        if (done === 1'b1) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if ((inst[2] !== prev_xrd) || ((inst[32] === 1'b0) !== prev_ofrd)) n_lag <= n_lag + 1;
        if (inst[34] !== 1'b0 || inst[33] !== 1'b0 || inst[18] !== 1'b1 || inst[5:4] !== 2'b00 ||
            inst[31] !== inst[32] || (inst[0] === 1'b1 && inst[3] !== 1'b1) ||
            (inst[1] === 1'b1 && inst[3] !== 1'b1))
            n_bad <= n_bad + 1;
        prev_xrd  <= (inst[19] === 1'b0);
        prev_ofrd <= (inst[6] === 1'b1);
    end

    typedef struct {
        logic [10:0] w_base;
        logic [10:0] x_base;
        logic [10:0] p_base;
        bit          stall;
        bit          ofifo_gap;
        bit          rdy_gap;
        bit          extra_start;
        logic [10:0] w_last;
        logic [10:0] x_last;
        logic [10:0] p_last;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected j-th XMEM read of a tile: 8 weights then 4 activations per pass.
    function automatic logic [10:0] exp_xaddr(input vec_t v, input int j);
        int k;
        int i;
        k = j / 12;
        i = j % 12;
        if (i < 8) return v.w_base + 11'(k * 8 + i);
        else return v.x_base + 11'(i - 8);
    endfunction

    task automatic run_tile(input vec_t v, input string tag);
        int x0, p0, l0, ld0, ex0, of0, d0, lg0, bc0, n, bad;
        bit got;
        logic [10:0] wl, xl, pl;
        x0 = xq.size(); p0 = pq.size(); l0 = n_l0wr; ld0 = n_load; ex0 = n_exec;
        of0 = n_ofrd; d0 = n_done; lg0 = n_lag; bc0 = n_bad;
        @(posedge clk); #1;
        w_base = v.w_base; x_base = v.x_base; p_base = v.p_base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; w_base = 11'd7; x_base = 11'd9; p_base = 11'd13;
        n = 1;
        got = 1'b0;
        while (!got && n < 2000) begin
            l0_full     = v.stall && (n >= 3) && (n < 6);
            ofifo_valid = v.ofifo_gap ? ((n % 2) == 1) : 1'b1;
            l0_ready    = v.rdy_gap ? ((n % 3) != 0) : 1'b1;
            start       = v.extra_start && (n == 20);
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                chk({tag, " busy_at_done"}, busy, 0);
            end
            @(posedge clk); #1;
            n++;
        end
        l0_full = 1'b0; ofifo_valid = 1'b1; l0_ready = 1'b1; start = 1'b0;
        chk({tag, " done_seen"}, got, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk({tag, " xmem_reads"}, xq.size() - x0, 36);
        bad = 0;
        for (int j = 0; j < 36; j++)
            if (x0 + j >= xq.size() || xq[x0 + j] !== exp_xaddr(v, j)) bad++;
        chk({tag, " xmem_seq_bad"}, bad, 0);
        wl = (xq.size() >= x0 + 36) ? xq[x0 + 31] : 11'h7FF;
        xl = (xq.size() >= x0 + 36) ? xq[x0 + 35] : 11'h7FF;
        chk({tag, " w_last"}, wl, v.w_last);
        chk({tag, " x_last"}, xl, v.x_last);
        chk({tag, " l0_wr"}, n_l0wr - l0, 36);
        chk({tag, " loads"}, n_load - ld0, 24);
        chk({tag, " execs"}, n_exec - ex0, 12);
        chk({tag, " ofifo_rd"}, n_ofrd - of0, 12);
        chk({tag, " pmem_writes"}, pq.size() - p0, 12);
        bad = 0;
        for (int j = 0; j < 12; j++)
            if (p0 + j >= pq.size() || pq[p0 + j] !== v.p_base + 11'(j)) bad++;
        chk({tag, " pmem_seq_bad"}, bad, 0);
        pl = (pq.size() >= p0 + 12) ? pq[p0 + 11] : 11'h7FF;
        chk({tag, " p_last"}, pl, v.p_last);
        chk({tag, " done_count"}, n_done - d0, 1);
        chk({tag, " done_after_pw"}, done_cyc - last_pw_cyc, 1);
        chk({tag, " lag_errs"}, n_lag - lg0, 0);
        chk({tag, " const_errs"}, n_bad - bc0, 0);
        chk({tag, " end_inst"}, inst, IDLE_WORD);
        chk({tag, " end_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{11'd0,    11'd64,   11'd0,    1'b0, 1'b0, 1'b0, 1'b0, 11'd23,  11'd67,  11'd11};
        vecs[1] = '{11'd100,  11'd300,  11'd500,  1'b1, 1'b0, 1'b0, 1'b0, 11'd123, 11'd303, 11'd511};
        vecs[2] = '{11'd2044, 11'd2046, 11'd2046, 1'b0, 1'b1, 1'b0, 1'b1, 11'd19,  11'd1,   11'd9};
        vecs[3] = '{11'd16,   11'd200,  11'd1000, 1'b1, 1'b1, 1'b1, 1'b0, 11'd39,  11'd203, 11'd1011};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_inst", inst, IDLE_WORD);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        // First-cycle timing: read right after start, l0_wr one cycle behind.
        @(posedge clk); #1;
        w_base = 11'd0; x_base = 11'd64; p_base = 11'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("first_rd_cen", inst[19], 0);
        chk("first_rd_addr", inst[17:7], 0);
        chk("first_l0_wr", inst[2], 0);
        chk("first_busy", busy, 1);
        @(negedge clk);
        chk("second_l0_wr", inst[2], 1);
        chk("second_rd_addr", inst[17:7], 1);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("timing_tile_done", done, 1);
        repeat (3) @(posedge clk);

        for (int i = 0; i < 4; i++) run_tile(vecs[i], $sformatf("vec%0d", i));

        // Reset while executing, then a clean tile.
        @(posedge clk); #1;
        w_base = 11'd0; x_base = 11'd64; p_base = 11'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(inst[1] === 1'b1 && inst[3] === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("exec_reached", inst[1], 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_exec_inst", inst, IDLE_WORD);
        chk("rst_exec_busy", busy, 0);
        chk("rst_exec_done", done, 0);
        run_tile(vecs[0], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/corelet_seq.md
# corelet_seq

Instruction sequencer driving the 35-bit `inst` bus of the corelet and its X/P SRAMs for one output tile. It issues kernel-position passes (`n_kij`). Each pass:
- streams `row` weight words from XMEM into L0 and loads them into the MAC array;
- streams `n_act` activation words and executes;
- drains `n_act` OFIFO psum words into PMEM.

It sits between the core top level and the corelet and replaces testbench-driven instruction streams.

## Interface
Parameters:
- `row`, 8: L0 lanes / weight words per kij
- `col`, 8: MAC columns
- `inst_width`, 35: instruction width
- `addr_w`, 11: SRAM address width
- `n_act`, 36: activation words per pass
- `n_kij`, 9: passes per tile

Ports:
- `clk`  in  1  clock; one clock domain
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; begins a tile when idle
- `w_base`  in  addr_w  XMEM base of weights
- `x_base`  in  addr_w  XMEM base of activations
- `p_base`  in  addr_w  PMEM base of psums
- `l0_full`  in  1  L0 cannot accept a write
- `l0_ready`  in  1  L0 all lanes hold data
- `ofifo_valid`  in  1  OFIFO holds a full psum row
- `inst`  out  inst_width  instruction word to corelet/SRAMs
- `busy`  out  1  high from first cycle after accepted start until done
- `done`  out  1  one-cycle pulse after the last PMEM write

## Operation
Instruction fields (bit positions fixed):
- 34 relu; 33 acc
- 32 CEN_PMEM, active-low; 31 WEN_PMEM, active-low; 30:20 A_PMEM
- 19 CEN_XMEM, active-low; 18 WEN_XMEM, active-low; 17:7 A_XMEM
- 6 ofifo_rd; 3 l0_rd; 2 l0_wr
- 1:0 MAC instruction: bit0 kernel-load, bit1 execute
- 5:4 unused; always 0
- relu, acc and WEN_XMEM are constant: relu=0, acc=0, WEN_XMEM=1. No XMEM writes; SFP accumulation is out of scope.
- Idle word: CEN_PMEM=1, WEN_PMEM=1, CEN_XMEM=1, WEN_XMEM=1, all other bits 0. This is also the reset value of `inst`.

States: IDLE → W_FILL → W_LOAD → X_FILL → EXEC → DRAIN → (next kij: W_FILL | last: DONE) → IDLE.

Counters: `kij` (0..n_kij-1) and `idx` (reused per state).
- **W_FILL:** each cycle with `!l0_full` and `idx<row`:
  - CEN_XMEM=0, A_XMEM=w_base+kij*row+idx, then idx++.
  - l0_wr is asserted exactly one cycle after each issued read (SRAM read latency 1).
  - Exit when idx==row and the final l0_wr has been issued.
- **W_LOAD:** for `col` cycles, assert l0_rd=1 and bit0=1, gated by `l0_ready`; a cycle with `!l0_ready` holds both low and does not count. Then `col` idle cycles let the load propagate.
- **X_FILL:** same as W_FILL with A_XMEM=x_base+idx, `n_act` words.
- **EXEC:** `n_act` counted cycles of l0_rd=1 with bit1=1, gated by `l0_ready`.
- **DRAIN:** when `ofifo_valid`, assert ofifo_rd=1.
  - The cycle after, assert CEN_PMEM=0, WEN_PMEM=0, A_PMEM=p_base+kij*n_act+idx, then idx++.
  - Exit after `n_act` writes.
- **DONE:** one cycle; `done`=1, `busy`=0, then IDLE.

Address arithmetic is modulo 2^addr_w; wrap is silent.

## Timing
- `start` is sampled in IDLE only; `start` while busy is ignored.
- Base inputs are captured on the accepted start cycle; later changes have no effect until the next tile.
- First XMEM read is issued in the cycle after start.
- `inst` is fully registered: no combinational path from any input to `inst`.
- A read and a one-cycle-late l0_wr may coincide in the same cycle; this is legal.
- If `l0_full` rises with a read in flight, the pending l0_wr still issues and no new read is issued.
- `ofifo_valid` dropping mid-DRAIN stalls DRAIN with no PMEM write. A pending write from a prior rd still completes.
- Reset in any state: next cycle IDLE, `inst` = idle word, `busy`=0, `done`=0, counters 0. No partial instruction is left asserted.

## Structure
- Shared package `core_inst_pkg`: field bit-position constants, IDLE_INST word, state enum. The corelet reuses the same constants.
- Single module; no sub-module. Registered output word is built from per-state field assignments.

## Test plan
- **Single pass** (row=col=8, n_act=4, n_kij=1, bases 0/64/0), L0/OFIFO always ready:
  - 8 XMEM reads at 0..7, then 8 l0_wr each one cycle later;
  - 8 load cycles; 4 reads at 64..67; 4 exec cycles;
  - 4 PMEM writes at 0..3; `done` pulse; `inst` returns to the idle word.
- **n_kij=3:** weight addresses 0..23 in three blocks; PMEM addresses 0..11; exactly one `done`.
- **Backpressure:** hold `l0_full` for 3 cycles during W_FILL → XMEM address frozen, no lost or duplicate l0_wr; totals unchanged.
- **OFIFO gaps:** toggle `ofifo_valid` every other cycle in DRAIN → PMEM writes only after rd cycles; addresses contiguous.
- **Reset mid-EXEC** → next cycle `inst` = idle word, `busy`=0; a new `start` runs a full clean tile.
- **Wrap and ignored start:** p_base=2046, n_act=4 → PMEM writes at 2046, 2047, 0, 1. A `start` pulse while busy → no effect.
